// File: rtl/reset_sequencer_if.sv
// Control and status bundle of the reset sequencer: software reset handshake
// plus the sequenced reset outputs and status flags.
interface reset_sequencer_if #(
  parameter int NUM_OUT = 4
);
  logic               sw_rst_req;
  logic [NUM_OUT-1:0] rst_n_out;
  logic               rst_done;
  logic               busy;
  logic               sw_rst_ack;

  modport master (
    output sw_rst_req,
    input  rst_n_out, rst_done, busy, sw_rst_ack
  );

  modport slave (
    input  sw_rst_req,
    output rst_n_out, rst_done, busy, sw_rst_ack
  );
endinterface

// File: rtl/reset_sequencer.sv
// Root reset generator for one clock domain: async assert, synchronised
// deassert, minimum hold, then staggered release of NUM_OUT resets.
module reset_sequencer #(
  parameter int SYNC_STAGES       = 2,
  parameter int NUM_OUT           = 4,
  parameter int MIN_ASSERT_CYCLES = 8,
  parameter int STAGGER_CYCLES    = 16
) (
  input  logic             clk,
  input  logic             rst_n_in,
  reset_sequencer_if.slave bus
);

  localparam int MAX_MT = (MIN_ASSERT_CYCLES > STAGGER_CYCLES) ? MIN_ASSERT_CYCLES
                                                               : STAGGER_CYCLES;
  localparam int CNT_W  = $clog2(MAX_MT) + 1;
  localparam int IDX_W  = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0]   M_LAST   = CNT_W'(MIN_ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   T_LAST   = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OUT - 1);
  localparam logic [NUM_OUT-1:0] BIT0     = NUM_OUT'(1);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("reset_sequencer: SYNC_STAGES must be at least 2");
  end
  if (NUM_OUT < 1 || MIN_ASSERT_CYCLES < 1 || STAGGER_CYCLES < 1) begin : g_bad_cfg
    $error("reset_sequencer: NUM_OUT, MIN_ASSERT_CYCLES and STAGGER_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RESET,
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state,     w_state_nxt;
  logic [CNT_W-1:0]       r_cnt,       w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx,       w_idx_nxt;
  logic [NUM_OUT-1:0]     r_rst_n_out, w_rst_n_nxt;
  logic                   r_rst_done,  w_done_nxt;
  logic                   r_busy;
  logic                   r_ack,       w_ack_nxt;
  logic                   w_sync_ok;

  assign w_sync_ok = r_sync[SYNC_STAGES-1];

  // NOTE: every flop, including the sync chain, clears on the async reset and
  // is updated with non-blocking assignments so all state moves on one edge.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_sync      <= '0;
      r_state     <= ST_RESET;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rst_n_out <= '0;
      r_rst_done  <= 1'b0;
      r_busy      <= 1'b1;
      r_ack       <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], 1'b1};
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_rst_n_out <= w_rst_n_nxt;
      r_rst_done  <= w_done_nxt;
      r_busy      <= (w_state_nxt != ST_RUN);
      r_ack       <= w_ack_nxt;
    end
  end

  // NOTE: all next-state values take a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_rst_n_nxt = r_rst_n_out;
    w_done_nxt  = r_rst_done;
    w_ack_nxt   = 1'b0;

    unique case (r_state)
      ST_RESET: begin
        if (w_sync_ok) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
      end

      ST_HOLD: begin
        if (r_cnt == M_LAST) begin
          w_rst_n_nxt = r_rst_n_out | BIT0;
          w_cnt_nxt   = '0;
          if (NUM_OUT == 1) begin
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_RELEASE;
            w_idx_nxt   = IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_RELEASE: begin
        if (r_cnt == T_LAST) begin
          w_rst_n_nxt = r_rst_n_out | (BIT0 << r_idx);
          w_cnt_nxt   = '0;
          w_idx_nxt   = r_idx + IDX_W'(1);
          if (r_idx == LAST_IDX) begin
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_RUN: begin
        // A request sampled on the edge that enters RUN is seen only here, one edge later.
        if (bus.sw_rst_req) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_rst_n_nxt = '0;
          w_done_nxt  = 1'b0;
          w_ack_nxt   = 1'b1;
        end
      end

      default: w_state_nxt = ST_RESET;
    endcase
  end

  assign bus.rst_n_out  = r_rst_n_out;
  assign bus.rst_done   = r_rst_done;
  assign bus.busy       = r_busy;
  assign bus.sw_rst_ack = r_ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: edge-count reference model compared
// every cycle, plus literal timing points and a minimum-parameter instance.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int S        = 2;
  localparam int N        = 4;
  localparam int M        = 8;
  localparam int T        = 16;
  localparam int LAST_OFF = M + (N - 1) * T;
  localparam int NEVER    = 1_000_000;

  logic clk = 1'b0;
  logic rst_n_in;
  logic rst_n2;

  int n_cmp = 0;
  int n_err = 0;

  reset_sequencer_if #(.NUM_OUT(N)) sq_if ();
  reset_sequencer_if #(.NUM_OUT(1)) mn_if ();

  reset_sequencer #(
    .SYNC_STAGES(S), .NUM_OUT(N), .MIN_ASSERT_CYCLES(M), .STAGGER_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n_in(rst_n_in), .bus(sq_if.slave)
  );

  reset_sequencer #(
    .SYNC_STAGES(3), .NUM_OUT(1), .MIN_ASSERT_CYCLES(1), .STAGGER_CYCLES(1)
  ) dut_min (
    .clk(clk), .rst_n_in(rst_n2), .bus(mn_if.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: m_edge is the edge number since rst_n_in rose, m_t0 the
  // edge at which the current hold period began. Bit k is released once
  // M + k*T edges have passed since m_t0.
  int   m_edge = 0;
  int   m_t0   = NEVER;
  logic m_ack  = 1'b0;

  always @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_edge <= 0;
      m_t0   <= NEVER;
      m_ack  <= 1'b0;
    end else begin
      m_edge <= m_edge + 1;
      m_ack  <= 1'b0;
      if (m_edge + 1 == S + 1) begin
        m_t0 <= m_edge + 1;
      end else if (m_edge >= m_t0 + LAST_OFF && sq_if.sw_rst_req) begin
        m_t0  <= m_edge + 1;
        m_ack <= 1'b1;
      end
    end
  end

  function automatic logic [N-1:0] exp_out(input int e, input int t0);
    exp_out = '0;
    for (int k = 0; k < N; k++) exp_out[k] = (e >= t0 + M + k * T);
  endfunction

  always @(negedge clk) begin
    check("cyc_rst_n_out", 32'(sq_if.rst_n_out), 32'(exp_out(m_edge, m_t0)));
    check("cyc_rst_done",  32'(sq_if.rst_done),  32'(m_edge >= m_t0 + LAST_OFF));
    check("cyc_busy",      32'(sq_if.busy),      32'(!(m_edge >= m_t0 + LAST_OFF)));
    check("cyc_sw_ack",    32'(sq_if.sw_rst_ack), 32'(m_ack));
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n_in = 1'b1;
    rst_n2   = 1'b1;
    sq_if.sw_rst_req = 1'b0;
    mn_if.sw_rst_req = 1'b0;
    #1;
    rst_n_in = 1'b0;
    rst_n2   = 1'b0;

    // Power-on with defaults; minimum-parameter instance released alongside.
    repeat (5) @(posedge clk);
    #2;
    rst_n_in = 1'b1;
    rst_n2   = 1'b1;
    for (int e = 1; e <= 59; e++) begin
      edge1();
      if (e == 4)  begin
        check("min_e4_out",  32'(mn_if.rst_n_out), 32'd0);
        check("min_e4_done", 32'(mn_if.rst_done),  32'd0);
      end
      if (e == 5)  begin
        check("min_e5_out",  32'(mn_if.rst_n_out), 32'd1);
        check("min_e5_done", 32'(mn_if.rst_done),  32'd1);
      end
      if (e == 10) check("por_e10_out", 32'(sq_if.rst_n_out), 32'b0000);
      if (e == 11) check("por_e11_out", 32'(sq_if.rst_n_out), 32'b0001);
      if (e == 26) check("por_e26_out", 32'(sq_if.rst_n_out), 32'b0001);
      if (e == 27) check("por_e27_out", 32'(sq_if.rst_n_out), 32'b0011);
      if (e == 43) check("por_e43_out", 32'(sq_if.rst_n_out), 32'b0111);
      if (e == 58) check("por_e58_busy", 32'(sq_if.busy), 32'd1);
      if (e == 59) begin
        check("por_e59_out",  32'(sq_if.rst_n_out), 32'b1111);
        check("por_e59_done", 32'(sq_if.rst_done),  32'd1);
        check("por_e59_busy", 32'(sq_if.busy),      32'd0);
      end
    end

    // Single-cycle software reset request in RUN.
    repeat (3) edge1();
    #1 sq_if.sw_rst_req = 1'b1;
    edge1();
    check("sw_e_out", 32'(sq_if.rst_n_out), 32'b0000);
    check("sw_e_ack", 32'(sq_if.sw_rst_ack), 32'd1);
    #1 sq_if.sw_rst_req = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      edge1();
      if (k == 1)  check("sw_e1_ack",  32'(sq_if.sw_rst_ack), 32'd0);
      if (k == 7)  check("sw_e7_out",  32'(sq_if.rst_n_out), 32'b0000);
      if (k == 8)  check("sw_e8_out",  32'(sq_if.rst_n_out), 32'b0001);
      if (k == 24) check("sw_e24_out", 32'(sq_if.rst_n_out), 32'b0011);
      if (k == 40) check("sw_e40_out", 32'(sq_if.rst_n_out), 32'b0111);
      if (k == 56) check("sw_e56_done", 32'(sq_if.rst_done), 32'd1);
    end

    // Requests during HOLD/RELEASE are ignored; one held into RUN is taken an edge later.
    #1 sq_if.sw_rst_req = 1'b1;
    edge1();
    check("ign_e_ack", 32'(sq_if.sw_rst_ack), 32'd1);
    #1 sq_if.sw_rst_req = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 57; k++) begin
      edge1();
      if (k == 56) begin
        check("ign_e56_done", 32'(sq_if.rst_done),   32'd1);
        check("ign_e56_ack",  32'(sq_if.sw_rst_ack), 32'd0);
      end
      if (k == 57) begin
        check("ign_e57_ack", 32'(sq_if.sw_rst_ack), 32'd1);
        check("ign_e57_out", 32'(sq_if.rst_n_out),  32'b0000);
      end
      #1;
      if (k >= 49 && k < 57) sq_if.sw_rst_req = 1'b1;
      else if (k == 57)      sq_if.sw_rst_req = 1'b0;
      else                   sq_if.sw_rst_req = 1'($urandom_range(0, 1));
    end
    repeat (60) edge1();

    // Asynchronous assertion from RUN, checked between edges.
    #2 rst_n_in = 1'b0;
    #1;
    check("async_out",  32'(sq_if.rst_n_out), 32'b0000);
    check("async_done", 32'(sq_if.rst_done),  32'd0);
    check("async_busy", 32'(sq_if.busy),      32'd1);
    repeat (2) edge1();
    #1 rst_n_in = 1'b1;

    // Sub-cycle glitch after bit 1 has released, then full restart.
    for (int e = 1; e <= 30; e++) begin
      edge1();
      if (e == 27) check("gl_e27_out", 32'(sq_if.rst_n_out), 32'b0011);
    end
    #2 rst_n_in = 1'b0;
    #1;
    check("gl_low_out",  32'(sq_if.rst_n_out), 32'b0000);
    check("gl_low_busy", 32'(sq_if.busy),      32'd1);
    rst_n_in = 1'b1;
    for (int e = 1; e <= 59; e++) begin
      edge1();
      if (e == 10) check("gl_e10_out", 32'(sq_if.rst_n_out), 32'b0000);
      if (e == 11) check("gl_e11_out", 32'(sq_if.rst_n_out), 32'b0001);
      if (e == 27) check("gl_e27b_out", 32'(sq_if.rst_n_out), 32'b0011);
      if (e == 59) check("gl_e59_done", 32'(sq_if.rst_done), 32'd1);
    end

    // Randomised requests and occasional sub-cycle reset glitches.
    for (int c = 0; c < 1500; c++) begin
      edge1();
      #1 sq_if.sw_rst_req = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n_in = 1'b0;
        #1 rst_n_in = 1'b1;
      end
    end

    edge1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Parametrised reset synchroniser and sequencer for one clock domain. It asserts all downstream resets asynchronously, synchronises deassertion through a configurable-depth flop chain, and holds reset for a minimum time. It then releases NUM_OUT reset outputs in staggered order and accepts a synchronous software reset request once the sequence completes. It sits at the root of each clock domain's reset tree, ahead of FIFO pointer logic and datapath blocks that must come out of reset in a fixed order.

## Interface
- SYNC_STAGES, 2 — synchroniser depth for rst_n_in deassertion; values below 2 are an elaboration error.
- NUM_OUT, 4 — number of sequenced reset outputs; must be at least 1.
- MIN_ASSERT_CYCLES, 8 — cycles held in reset after synchronised deassertion (M); must be at least 1.
- STAGGER_CYCLES, 16 — cycles between consecutive output releases (T); must be at least 1.
- Counter width is derived as clog2 of max(M, T) plus 1. It is not user-settable.

Ports:
- clk  in  1  domain clock.
- rst_n_in  in  1  reset, asynchronous, active-low; clock clk.
- sw_rst_req  in  1  synchronous software reset request, level-sampled.
- rst_n_out  out  NUM_OUT  sequenced active-low resets; bit 0 is released first.
- rst_done  out  1  high once all outputs are released.
- busy  out  1  high whenever state is not RUN.
- sw_rst_ack  out  1  one-cycle pulse when a software reset is accepted.

## Operation
- rst_n_in low causes, asynchronously:
  - sync chain cleared;
  - state = RESET;
  - cnt = 0, idx = 0;
  - rst_n_out = all 0;
  - rst_done = 0, busy = 1, sw_rst_ack = 0.
- Sync chain: a shift register of SYNC_STAGES flops shifting in 1. Its last stage is sync_ok.
- All outputs are registered. There are no combinational paths from any input to any output.
- RESET state: when sync_ok = 1, go to HOLD with cnt = 0.
- HOLD state: cnt increments each cycle. When cnt == M-1:
  - set rst_n_out[0] = 1.
  - If NUM_OUT == 1: go to RUN and set rst_done = 1.
  - Otherwise: go to RELEASE with cnt = 0, idx = 1.
- RELEASE state: cnt increments each cycle. When cnt == T-1:
  - set rst_n_out[idx] = 1, cnt = 0, idx = idx+1.
  - If idx was NUM_OUT-1: go to RUN and set rst_done = 1 on the same edge.
- RUN state: if sw_rst_req == 1 at a clock edge:
  - rst_n_out = all 0, rst_done = 0;
  - sw_rst_ack = 1 for exactly one cycle;
  - go to HOLD with cnt = 0.
- sw_rst_req outside RUN is ignored and produces no ack.
- If sw_rst_req is held high, a new software reset is accepted each time RUN is reached.
- Outputs already released stay high until the next reset. Release order is strictly bit 0 upward.

## Timing
- Edge numbering: edge 1 is the first clk rising edge at which rst_n_in is sampled high.
- Power-on sequence (S = SYNC_STAGES):
  - sync_ok rises at edge S.
  - HOLD is entered at edge S+1.
  - rst_n_out[k] rises at edge S+1+M+k·T.
  - rst_done and busy deassertion coincide with the release of bit NUM_OUT-1.
- With defaults, bits 0..3 release at edges 11, 27, 43 and 59. rst_done rises at edge 59.
- Software reset accepted at edge E:
  - outputs drop at edge E;
  - sw_rst_ack is high for cycle E..E+1;
  - rst_n_out[k] rises at edge E+M+k·T.
- Assertion latency from rst_n_in falling to outputs low is zero clock cycles (asynchronous).
- rst_n_in glitch mid-sequence (any state): full asynchronous clear, then the sequence restarts from edge 1 after the next deassertion. There is no partial resume.
- A software reset request on the same edge that RUN is entered is not sampled; the earliest acceptance is the following edge.

## Test plan
- Power-on with defaults: rst_n_in low for 5 cycles, then high → rst_n_out bits rise at edges 11/27/43/59; rst_done = 1 and busy = 0 from edge 59; sw_rst_ack stays 0.
- Async assertion: in RUN, drop rst_n_in between clock edges → rst_n_out = 0000, rst_done = 0, busy = 1 before the next edge.
- Mid-sequence glitch: pulse rst_n_in low for less than one cycle after bit 1 has released → all bits low; re-release at edges 11/27/43/59 relative to the new deassertion.
- Software reset: in RUN, assert sw_rst_req for 1 cycle at edge E → sw_rst_ack high for 1 cycle; outputs 0000 at E; bits rise at E+8, E+24, E+40, E+56.
- Ignored request: sw_rst_req high during HOLD/RELEASE → no ack and no timing change. If still high when RUN is entered, it is accepted one edge later.
- Parameter sweep SYNC_STAGES = 3, NUM_OUT = 1, M = 1, T = 1 → rst_n_out[0] and rst_done rise at edge 5. Elaboration with SYNC_STAGES = 1 fails.
